// File: rtl/l2cache_req_arbiter.sv
// rtl/l2cache_req_arbiter.sv - single-outstanding icache/dcache request arbiter feeding the L2 cache FSM
module l2cache_req_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              icache_l2cache_req,
  input  logic [ADDR_W-1:0] icache_l2cache_addr,
  output logic              l2arb_icache_addrOK,
  output logic              l2arb_icache_dataOK,
  input  logic              dcache_l2cache_req,
  input  logic              dcache_l2cache_wr,
  input  logic [ADDR_W-1:0] dcache_l2cache_addr,
  input  logic [DATA_W-1:0] dcache_l2cache_wdata,
  output logic              l2arb_dcache_addrOK,
  output logic              l2arb_dcache_dataOK,
  output logic [1:0]        arb_l2cache_from,
  output logic [ADDR_W-1:0] arb_l2cache_addr,
  output logic [DATA_W-1:0] arb_l2cache_wdata,
  input  logic              l2cache_arb_addrOK,
  input  logic              l2cache_arb_dataOK,
  input  logic [DATA_W-1:0] l2cache_arb_rdata,
  output logic [DATA_W-1:0] arb_rdata,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner_d;
  logic              r_wr;
  logic              r_last_d;
  logic              r_timeout;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              w_grant_i;
  logic              w_grant_d;

  assign arb_l2cache_addr  = r_addr;
  assign arb_l2cache_wdata = r_wdata;
  assign arb_rdata         = l2cache_arb_rdata;
  assign timeout_err       = r_timeout;

  // Round-robin grant: under contention the requester not served last wins
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (rstn && (r_state == S_IDLE)) begin
      if (icache_l2cache_req && dcache_l2cache_req) begin
        w_grant_i = r_last_d;
        w_grant_d = ~r_last_d;
      end else begin
        w_grant_i = icache_l2cache_req;
        w_grant_d = dcache_l2cache_req;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state, L2 command code and upstream handshake pulses (pulses are masked while in reset)
  always_comb begin
    w_next              = r_state;
    l2arb_icache_addrOK = 1'b0;
    l2arb_dcache_addrOK = 1'b0;
    l2arb_icache_dataOK = 1'b0;
    l2arb_dcache_dataOK = 1'b0;
    arb_l2cache_from    = 2'b00;
    case (r_state)
      S_IDLE: begin
        l2arb_icache_addrOK = w_grant_i;
        l2arb_dcache_addrOK = w_grant_d;
        if (w_grant_i || w_grant_d) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        arb_l2cache_from = r_owner_d ? {1'b1, r_wr} : 2'b01;
        if (l2cache_arb_addrOK) begin
          if (r_owner_d && r_wr) begin
            l2arb_dcache_dataOK = rstn;
            w_next              = S_IDLE;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (l2cache_arb_dataOK) begin
          l2arb_icache_dataOK = rstn & ~r_owner_d;
          l2arb_dcache_dataOK = rstn & r_owner_d;
          w_next              = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the winning request; requester inputs are ignored until the next grant
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
      r_last_d  <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_grant_i) begin
      r_owner_d <= 1'b0;
      r_wr      <= 1'b0;
      r_last_d  <= 1'b0;
      r_addr    <= icache_l2cache_addr;
    end else if (w_grant_d) begin
      r_owner_d <= 1'b1;
      r_wr      <= dcache_l2cache_wr;
      r_last_d  <= 1'b1;
      r_addr    <= dcache_l2cache_addr;
      r_wdata   <= dcache_l2cache_wdata;
    end
  end

  // Watchdog: counts busy cycles of the current transaction, flag is sticky once the limit is hit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_grant_i || w_grant_d) begin
      r_wait_cnt <= '0;
    end else if ((r_state != S_IDLE) && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_wait_cnt == (CNT_MAX - 1'b1)) r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2cache_req_arbiter.sv
// tb/tb_l2cache_req_arbiter.sv - transaction-level self-checking bench for l2cache_req_arbiter
module tb_l2cache_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          icache_l2cache_req;
  logic [AW-1:0] icache_l2cache_addr;
  logic          l2arb_icache_addrOK;
  logic          l2arb_icache_dataOK;
  logic          dcache_l2cache_req;
  logic          dcache_l2cache_wr;
  logic [AW-1:0] dcache_l2cache_addr;
  logic [DW-1:0] dcache_l2cache_wdata;
  logic          l2arb_dcache_addrOK;
  logic          l2arb_dcache_dataOK;
  logic [1:0]    arb_l2cache_from;
  logic [AW-1:0] arb_l2cache_addr;
  logic [DW-1:0] arb_l2cache_wdata;
  logic          l2cache_arb_addrOK;
  logic          l2cache_arb_dataOK;
  logic [DW-1:0] l2cache_arb_rdata;
  logic [DW-1:0] arb_rdata;
  logic          timeout_err;

  always #5 clk = ~clk;

  l2cache_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .icache_l2cache_req   (icache_l2cache_req),
    .icache_l2cache_addr  (icache_l2cache_addr),
    .l2arb_icache_addrOK  (l2arb_icache_addrOK),
    .l2arb_icache_dataOK  (l2arb_icache_dataOK),
    .dcache_l2cache_req   (dcache_l2cache_req),
    .dcache_l2cache_wr    (dcache_l2cache_wr),
    .dcache_l2cache_addr  (dcache_l2cache_addr),
    .dcache_l2cache_wdata (dcache_l2cache_wdata),
    .l2arb_dcache_addrOK  (l2arb_dcache_addrOK),
    .l2arb_dcache_dataOK  (l2arb_dcache_dataOK),
    .arb_l2cache_from     (arb_l2cache_from),
    .arb_l2cache_addr     (arb_l2cache_addr),
    .arb_l2cache_wdata    (arb_l2cache_wdata),
    .l2cache_arb_addrOK   (l2cache_arb_addrOK),
    .l2cache_arb_dataOK   (l2cache_arb_dataOK),
    .l2cache_arb_rdata    (l2cache_arb_rdata),
    .arb_rdata            (arb_rdata),
    .timeout_err          (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // requester side: outstanding (not yet accepted) requests
  bit          pend_i, pend_d, rq_wr;
  logic [AW-1:0] rq_addr_i, rq_addr_d;
  logic [DW-1:0] rq_wdata;
  // transaction in flight: 0 idle, 1 address phase, 2 data phase
  int          phase;
  bit          own_d, own_wr, last_d, err_exp;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  int          issue_left, wait_left, elapsed;
  int          force_issue = -1;
  int          force_wait  = -1;
  bit          gen_en, rst_now, force_l2d;
  bit          grant_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive requesters and L2, predict outputs, check, advance the model
  task automatic cycle();
    bit w_i, w_d, l2a, l2d;
    logic [DW-1:0] rd;
    logic [1:0] exp_from;
    if (gen_en && !pend_i && $urandom_range(0, 2) == 0) begin
      pend_i = 1'b1; rq_addr_i = $urandom;
    end
    if (gen_en && !pend_d && $urandom_range(0, 2) == 0) begin
      pend_d = 1'b1; rq_wr = 1'($urandom_range(0, 1)); rq_addr_d = $urandom; rq_wdata = $urandom;
    end
    rstn                 = !rst_now;
    icache_l2cache_req   = pend_i;
    icache_l2cache_addr  = pend_i ? rq_addr_i : AW'($urandom);
    dcache_l2cache_req   = pend_d;
    dcache_l2cache_wr    = pend_d ? rq_wr : 1'($urandom_range(0, 1));
    dcache_l2cache_addr  = pend_d ? rq_addr_d : AW'($urandom);
    dcache_l2cache_wdata = pend_d ? rq_wdata : DW'($urandom);
    w_i = 1'b0; w_d = 1'b0; l2a = 1'b0; l2d = 1'b0;
    rd = $urandom;
    case (phase)
      0: begin
        if (!rst_now) begin
          if (pend_i && pend_d) begin w_i = last_d; w_d = !last_d; end
          else begin w_i = pend_i; w_d = pend_d; end
        end
        l2d = force_l2d || ($urandom_range(0, 3) == 0);
      end
      1: begin
        l2a = (issue_left == 0);
        l2d = force_l2d || ($urandom_range(0, 3) == 0);
      end
      default: l2d = (wait_left == 0);
    endcase
    l2cache_arb_addrOK = l2a;
    l2cache_arb_dataOK = l2d;
    l2cache_arb_rdata  = rd;
    #2;
    exp_from = (phase == 1) ? (own_d ? (own_wr ? 2'b11 : 2'b10) : 2'b01) : 2'b00;
    check("i_addrOK", l2arb_icache_addrOK, w_i);
    check("d_addrOK", l2arb_dcache_addrOK, w_d);
    check("i_dataOK", l2arb_icache_dataOK, !rst_now && phase == 2 && l2d && !own_d);
    check("d_dataOK", l2arb_dcache_dataOK,
          !rst_now && ((phase == 2 && l2d && own_d) || (phase == 1 && l2a && own_wr)));
    check("rdata", arb_rdata, rd);
    if (!rst_now) begin
      check("from", arb_l2cache_from, exp_from);
      check("addr", arb_l2cache_addr, cap_addr);
      check("wdata", arb_l2cache_wdata, cap_wdata);
      check("timeout", timeout_err, err_exp);
    end
    if (rst_now) begin
      phase = 0; err_exp = 1'b0; last_d = 1'b1; cap_addr = '0; cap_wdata = '0; elapsed = 0;
    end else begin
      case (phase)
        0: if (w_i || w_d) begin
          phase    = 1;
          own_d    = w_d;
          own_wr   = w_d && rq_wr;
          cap_addr = w_d ? rq_addr_d : rq_addr_i;
          if (w_d) begin cap_wdata = rq_wdata; pend_d = 1'b0; end
          else pend_i = 1'b0;
          last_d = w_d;
          grant_log.push_back(w_d);
          elapsed    = 0;
          issue_left = (force_issue >= 0) ? force_issue : $urandom_range(0, 6);
          wait_left  = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
          force_issue = -1;
          force_wait  = -1;
        end
        1: begin
          elapsed++;
          if (elapsed >= MW) err_exp = 1'b1;
          if (issue_left == 0) phase = own_wr ? 0 : 2;
          else issue_left--;
        end
        default: begin
          elapsed++;
          if (elapsed >= MW) err_exp = 1'b1;
          if (wait_left == 0) phase = 0;
          else wait_left--;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle();
    int n = 0;
    do begin cycle(); n++; end while (phase != 0 && n < 40);
    if (phase != 0) begin
      bad++;
      $display("FAIL idle_budget transaction still open after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; icache_l2cache_req = 1'b0; dcache_l2cache_req = 1'b0;
    icache_l2cache_addr = '0; dcache_l2cache_addr = '0; dcache_l2cache_wr = 1'b0;
    dcache_l2cache_wdata = '0; l2cache_arb_addrOK = 1'b0; l2cache_arb_dataOK = 1'b0;
    l2cache_arb_rdata = '0;
    pend_i = 0; pend_d = 0; rq_wr = 0; rq_addr_i = '0; rq_addr_d = '0; rq_wdata = '0;
    phase = 0; own_d = 0; own_wr = 0; last_d = 1; err_exp = 0; cap_addr = '0; cap_wdata = '0;
    issue_left = 0; wait_left = 0; elapsed = 0; gen_en = 0; rst_now = 0; force_l2d = 0;
    @(posedge clk);
    #1;

    // reset state
    do_reset();
    do_reset();
    cycle();

    // single icache read: L2 addrOK 2 cycles after grant, dataOK 3 cycles after that
    pend_i = 1'b1; rq_addr_i = 32'h0000_1000;
    force_issue = 1; force_wait = 2;
    cycle();
    run_to_idle();
    cycle();

    // contention with both held: grants alternate I, D, I
    do_reset();
    grant_log.delete();
    pend_i = 1'b1; rq_addr_i = 32'h0000_3000;
    pend_d = 1'b1; rq_addr_d = 32'h0000_4000; rq_wr = 1'b0; rq_wdata = 32'h1111_2222;
    for (int t = 0; t < 60 && grant_log.size() < 3; t++) begin
      cycle();
      if (!pend_i) begin pend_i = 1'b1; rq_addr_i = $urandom; end
    end
    run_to_idle();
    pend_i = 1'b0; pend_d = 1'b0;
    check("rr_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check("rr_grant0", grant_log[0], 1'b0);
      check("rr_grant1", grant_log[1], 1'b1);
      check("rr_grant2", grant_log[2], 1'b0);
    end

    // dcache write: completes on L2 addrOK with no data phase
    pend_d = 1'b1; rq_wr = 1'b1; rq_addr_d = 32'h0000_2004; rq_wdata = 32'hDEAD_BEEF;
    force_issue = 2;
    cycle();
    run_to_idle();
    cycle();

    // watchdog: addrOK withheld 6 cycles, flag sets after 4 busy cycles and stays set
    do_reset();
    pend_i = 1'b1; rq_addr_i = 32'h0000_5000;
    force_issue = 6; force_wait = 1;
    cycle();
    run_to_idle();
    cycle();
    cycle();

    // reset while waiting for read data: transaction dropped, later L2 dataOK ignored
    pend_d = 1'b1; rq_wr = 1'b0; rq_addr_d = 32'h0000_6000; rq_wdata = 32'h0;
    force_issue = 4; force_wait = 5;
    cycle();
    for (int t = 0; t < 20 && phase != 2; t++) cycle();
    cycle();
    do_reset();
    force_l2d = 1'b1;
    cycle();
    cycle();
    force_l2d = 1'b0;

    // spurious L2 dataOK in address phase
    pend_i = 1'b1; rq_addr_i = 32'h0000_7000;
    force_issue = 3;
    force_l2d = 1'b1;
    cycle();
    cycle();
    cycle();
    force_l2d = 1'b0;
    run_to_idle();

    // randomized traffic
    do_reset();
    gen_en = 1'b1;
    for (int t = 0; t < 600; t++) cycle();
    gen_en = 1'b0;
    pend_i = 1'b0; pend_d = 1'b0;
    run_to_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
